display_scan_ctrl: RTL and testbench

- Sequencer for the multiplexed 4-digit 7-segment display of the binary counting game.
- Accepts a digit word from game logic over a valid/ready handshake and holds it in a pending buffer.
- Commits the buffer to a shadow register only at frame boundaries, so no digit tears mid-scan.
- Scans digits round-robin with a programmable dwell and an inter-digit blanking gap (anti-ghosting); drives segment and digit-enable pins.

---
 rtl/display_scan_ctrl_pkg.sv | 19 +
 rtl/display_scan_ctrl_seg7_decoder.sv | 11 +
 rtl/display_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: scan FSM state encodings and 7-segment patterns shared by display blocks.
`ifndef DISPLAY_SCAN_CTRL_PKG_SV
`define DISPLAY_SCAN_CTRL_PKG_SV
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Active-high {g,f,e,d,c,b,a}; element n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage
`endif

// File: rtl/display_scan_ctrl_seg7_decoder.sv
// seg7_decoder: combinational hex nibble to 7-segment glyph lookup.
module seg7_decoder
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-seg scan sequencer with frame-synchronous digit commit.
// Define LEADING_ZERO_BLANK_EN to blank digits above the highest nonzero nibble.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         dig_en,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] pending, shadow;
    logic                    pend_full;
    logic                    blank_done, show_done, last, commit, lz_blank;
    logic [3:0]              nib;
    logic [6:0]              seg_dec, seg_nx;
    logic [NUM_DIGITS-1:0]   dig_en_nx;
    logic                    fs_nx;

    assign blank_done = cnt == CNT_W'(BLANK_CYCLES - 1);
    assign show_done  = cnt == CNT_W'(DWELL_CYCLES - 1);
    assign last       = idx == IW'(NUM_DIGITS - 1);
    assign data_ready = ~pend_full;
    assign digit_idx  = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            seg         <= '0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            seg         <= seg_nx;
            dig_en      <= dig_en_nx;
            frame_start <= fs_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        idx_nx   = idx;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                BLANK: if (blank_done) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                end
                SHOW: if (show_done) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = last ? '0 : idx + IW'(1);
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they change in step with it.
    assign nib = shadow[4*idx_nx +: 4];

    seg7_decoder u_dec (
        .hex (nib),
        .seg (seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] hi;
    always_comb begin
        hi = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (shadow[4*i +: 4] != 4'd0) hi = IW'(i);
    end
    assign lz_blank = idx_nx > hi;
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_nx    = (state_nx == SHOW && !lz_blank) ? seg_dec : '0;
        dig_en_nx = (state_nx == SHOW) ? NUM_DIGITS'(1) << idx_nx : '0;
        fs_nx     = state_nx == BLANK && state != BLANK && idx_nx == '0;
    end

    // Shadow only changes at a frame wrap or while idle, so a frame never tears.
    assign commit = pend_full && (state == IDLE || (state == SHOW && show_done && last && en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pending   <= '0;
            shadow    <= '0;
        end else if (commit) begin
            shadow    <= pending;
            pend_full <= 1'b0;
        end else if (data_valid && !pend_full) begin
            pending   <= digit_data;
            pend_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vectors plus randomized run against a frame-timing reference model.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = N * SLOT;

    typedef struct {
        logic [15:0]     data;
        logic [3:0][6:0] seg;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, data_valid = 1'b0;
    logic [15:0] digit_data = '0;
    logic        data_ready, frame_start;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [1:0]  digit_idx;

    int checks = 0, errors = 0;

    logic [6:0] segs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    bit          m_run, m_full;
    int          m_t;
    logic [15:0] m_pend, m_shadow;
    vec_t        vecs [4];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .digit_data  (digit_data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .seg         (seg),
        .dig_en      (dig_en),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lz_blank(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        int h;
        h = 0;
        for (int i = 1; i < N; i++) if (m_shadow[4*i +: 4] != 4'd0) h = i;
        return d > h;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_full = 0; m_pend = '0; m_shadow = '0;
    endtask

    // Time since enable determines everything: slot = t % FRAME, digit = slot / SLOT.
    task automatic model_step();
        bit commit;
        commit = m_full && (!m_run || (en && (m_t % FRAME) == FRAME - 1));
        if (commit) begin
            m_shadow = m_pend;
            m_full   = 0;
        end else if (data_valid && !m_full) begin
            m_pend = digit_data;
            m_full = 1;
        end
        if (!en) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_model();
        int p, d;
        bit lit;
        logic [3:0] nib;
        p   = m_t % FRAME;
        d   = p / SLOT;
        lit = m_run && (p % SLOT) >= BL;
        nib = m_shadow[4*d +: 4];
        chk("seg", seg, (lit && !lz_blank(d)) ? 32'(segs[nib]) : 32'd0);
        chk("dig_en", dig_en, lit ? 32'(1) << d : 32'd0);
        chk("digit_idx", digit_idx, m_run ? d : 0);
        chk("frame_start", frame_start, 32'(m_run && p == 0));
        chk("data_ready", data_ready, 32'(!m_full));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin tick(); n++; end while (!frame_start && n < 3*FRAME);
        if (!frame_start) begin
            checks++; errors++;
            $display("FAIL frame_start_timeout: no pulse within %0d cycles", n);
        end
    endtask

    task automatic offer(input logic [15:0] w);
        int n;
        n = 0;
        while (!data_ready && n < 3*FRAME) begin tick(); n++; end
        digit_data = w; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("ready_drop", data_ready, 0);
    endtask

    task automatic frame_check(input string tag, input logic [3:0][6:0] exp);
        for (int d = 0; d < N; d++) begin
            repeat (BL) tick();
            chk($sformatf("%s_seg%0d", tag, d), seg, exp[d]);
            chk($sformatf("%s_dig%0d", tag, d), dig_en, 32'(1) << d);
            repeat (DW) tick();
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h12A5, {7'h06, 7'h5B, 7'h77, 7'h6D}};
        vecs[1] = '{16'hFEDC, {7'h71, 7'h79, 7'h5E, 7'h39}};
        vecs[2] = '{16'h9876, {7'h6F, 7'h7F, 7'h07, 7'h7D}};
        vecs[3] = '{16'h4B30, {7'h66, 7'h7C, 7'h4F, 7'h3F}};

        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_seg", seg, 0);
        chk("rst_dig_en", dig_en, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ready", data_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        wait_fs();
        n = 0;
        do begin tick(); n++; end while (!frame_start && n < 3*FRAME);
        chk("frame_period", n, FRAME);
        frame_check("zero", {4{7'h3F}});

        for (int i = 0; i < 4; i++) begin
            offer(vecs[i].data);
            wait_fs();
            frame_check($sformatf("vec%0d", i), vecs[i].seg);
        end

        offer(16'h12A5);
        digit_data = 16'hFEDC; data_valid = 1'b1;
        n = 0;
        while (!data_ready && n < 3*FRAME) begin tick(); n++; end
        chk("hold_ready", data_ready, 1);
        tick();
        data_valid = 1'b0;
        chk("held_accept", data_ready, 0);
        tick();
        chk("commit_seg0", seg, 7'h6D);
        wait_fs();
        repeat (BL) tick();
        chk("held_word_seg0", seg, 7'h39);

        wait_fs();
        repeat (2*SLOT + BL) tick();
        chk("show_dig2", dig_en, 4'b0100);
        en = 1'b0;
        tick();
        chk("off_seg", seg, 0);
        chk("off_dig_en", dig_en, 0);
        chk("off_idx", digit_idx, 0);
        en = 1'b1;
        tick();
        chk("restart_fs", frame_start, 1);
        repeat (BL) tick();
        chk("restart_dig0", dig_en, 4'b0001);

        offer(16'h9876);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_seg", seg, 0);
        chk("midrst_dig_en", dig_en, 0);
        chk("midrst_ready", data_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("postrst_fs", frame_start, 1);
        repeat (BL) tick();
        chk("postrst_seg0", seg, 7'h3F);
        chk("postrst_ready", data_ready, 1);

`ifdef LEADING_ZERO_BLANK_EN
        offer(16'h0007);
        wait_fs();
        frame_check("lz7", {7'h00, 7'h00, 7'h00, 7'h07});
        offer(16'h0000);
        wait_fs();
        frame_check("lz0", {7'h00, 7'h00, 7'h00, 7'h3F});
`endif

        repeat (1500) begin
            en         = $urandom_range(0, 99) != 0;
            data_valid = $urandom_range(0, 3) == 0;
            digit_data = 16'($urandom);
            tick();
        end
        data_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
